mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle control/datapath.
- Accepts single-word read (MemR) and write (MemW) requests issued by the control FSM during its load and store states.
- Holds a word-addressed internal RAM, inserts a programmable number of wait states, and returns a one-cycle Done pulse with registered ReadData.
- Sits between the datapath address mux (IoD-selected address) and the load path into the Mem2Reg mux.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, width of the Addr port
- DEPTH_LOG2, 10, log2 of RAM depth in words; RAM index = Addr[DEPTH_LOG2-1:0]
- WAIT_CYCLES, 2, wait states between accept and Done; legal range 0..15

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- MemR  input  1  read request strobe
- MemW  input  1  write request strobe
- Addr  input  ADDR_W  word address, sampled at accept
- WriteData  input  DATA_W  store data, sampled at accept
- Ready  output  1  responder can accept a request this cycle
- Busy  output  1  request in flight; always the inverse of Ready
- Done  output  1  one-cycle completion pulse
- ReadData  output  DATA_W  registered load data
- Err  output  1  error flag; tied 0 unless MEM_ERR_EN is defined

Behaviour:
- One clock (CLK). Reset is synchronous, active-high: sampled only on the CLK rising edge.
- Reset values:
  - State = IDLE, wait counter = 0, Ready = 1, Busy = 0.
  - Done = 0, ReadData = 0, Err = 0.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP.
  - Ready = 1 in IDLE and RESP; Ready = 0 in WAIT.
- Accept: an edge where Ready = 1 and (MemR | MemW) = 1.
  - Latches op, Addr and WriteData.
  - Next state: WAIT if WAIT_CYCLES > 0, else RESP.
  - The counter loads WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each cycle; on the cycle the counter is 0, the next state is RESP.
  - MemR/MemW in WAIT are ignored, not queued.
- RESP edge entry:
  - Write: RAM[idx] <= latched WriteData.
  - Read: ReadData <= RAM[idx].
  - Done = 1 for exactly the RESP cycle.
- Latency: accept at edge T puts Done = 1 in cycle T+1+WAIT_CYCLES. With WAIT_CYCLES = 0, Done appears the cycle after the request, which matches the LW1 -> LW2 sequence.
- ReadData holds its value until the next read enters RESP. Writes never alter ReadData.
- Back-to-back: a request present during RESP is accepted. Done and the new accept then coincide, giving one access per WAIT_CYCLES+1 cycles. With no request in RESP, the next state is IDLE.
- MemR and MemW both high at accept: treated as a write.
- Read-after-write to the same address: the read returns the new data, because the write is committed at the earlier RESP edge.
- Address wrap: bits of Addr above DEPTH_LOG2 are ignored, so access wraps modulo 2^DEPTH_LOG2.
- Reset mid-operation:
  - Reset in WAIT aborts the access: no RAM update, no Done.
  - Reset coinciding with the RESP-entry edge also suppresses the write and the Done.

Optional Feature:
- Macro: MEM_ERR_EN.
- Defined — accept-time checks:
  - Rejects a request with MemR & MemW both set.
  - Rejects a request with any Addr bit at or above DEPTH_LOG2 set.
  - A rejected request still goes through WAIT/RESP with normal latency, but the RAM and ReadData are untouched.
  - Err = 1 together with Done for the RESP cycle only.
- Undefined:
  - Err is constant 0.
  - MemR & MemW resolves to a write; out-of-range addresses wrap.

Test Plan:
- Reset, then idle 5 cycles -> Ready = 1, Busy = 0, Done = 0, ReadData = 0x0000 every cycle.
- WAIT_CYCLES = 2:
  - MemW Addr = 0x0004, WriteData = 0xBEEF at edge T -> Done = 1 only in cycle T+3.
  - Then MemR Addr = 0x0004 -> ReadData = 0xBEEF with Done three cycles after accept.
- WAIT_CYCLES = 0: MemR held in consecutive cycles, Addr = 1, 2, 3 -> Done high every cycle after the first, ReadData follows the RAM contents in order.
- MemR pulsed again during WAIT -> ignored; only one Done. Reset asserted in WAIT of a write to 0x0010 -> no Done, RAM[0x0010] unchanged.
- DEPTH_LOG2 = 10, MemW Addr = 0x0405, WriteData = 0x1234:
  - Without MEM_ERR_EN: RAM[0x005] = 0x1234, Err = 0.
  - With MEM_ERR_EN: RAM unchanged, Err = 1 with Done.
- MemR & MemW both high, Addr = 0x0002, WriteData = 0x00AA:
  - Without MEM_ERR_EN: write occurs, ReadData unchanged.
  - With MEM_ERR_EN: Err = 1, no write.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the control FSM and mem_responder.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              MemR;
  logic              MemW;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic              Ready;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] ReadData;
  logic              Err;

  modport master (
    output MemR, MemW, Addr, WriteData,
    input  Ready, Busy, Done, ReadData, Err
  );

  modport slave (
    input  MemR, MemW, Addr, WriteData,
    output Ready, Busy, Done, ReadData, Err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states and a one-cycle Done pulse.
// Define MEM_ERR_EN to reject dual-strobe and out-of-range requests and flag them on Err.
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           CLK,
  input  logic           Reset,
  mem_responder_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CntLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     mem [Depth];

  logic                  ready;
  logic                  accept;
  logic                  req_err;
  logic [ADDR_W-1:0]     addr_hi;
  logic                  cmt_wr;
  logic                  cmt_err;
  logic [DEPTH_LOG2-1:0] cmt_idx;
  logic [DATA_W-1:0]     cmt_wdata;
  logic                  commit;

  assign ready   = (state_q != StWait);
  assign accept  = ready & (bus.MemR | bus.MemW);
  assign addr_hi = bus.Addr >> DEPTH_LOG2;

`ifdef MEM_ERR_EN
  assign req_err = (bus.MemR & bus.MemW) | (|addr_hi);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |addr_hi;
  assign req_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Accept is only possible outside WAIT, so it may override the default path.
    if (accept) begin
      state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
      cnt_d   = CntLoad;
    end
  end

  // Entering RESP from WAIT uses the latched request; with zero wait states the
  // entry edge is the accept edge itself, so the live bus is used instead.
  always_comb begin
    if (state_q == StWait) begin
      cmt_wr    = wr_q;
      cmt_err   = err_q;
      cmt_idx   = idx_q;
      cmt_wdata = wdata_q;
    end else begin
      cmt_wr    = bus.MemW;
      cmt_err   = req_err;
      cmt_idx   = bus.Addr[DEPTH_LOG2-1:0];
      cmt_wdata = bus.WriteData;
    end
  end

  assign commit = (state_d == StResp) & ~Reset & ~cmt_err;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.MemW;
        idx_q   <= bus.Addr[DEPTH_LOG2-1:0];
        wdata_q <= bus.WriteData;
        err_q   <= req_err;
      end
      if (commit && !cmt_wr) begin
        rdata_q <= mem[cmt_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && cmt_wr) begin
      mem[cmt_idx] <= cmt_wdata;
    end
  end

  assign bus.Ready    = ready;
  assign bus.Busy     = ~ready;
  assign bus.Done     = (state_q == StResp);
  assign bus.ReadData = rdata_q;
  assign bus.Err      = (state_q == StResp) & err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a simple array model (WAIT_CYCLES 2 and 0).
module tb_mem_responder;

  localparam int NW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) b2 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) b0 ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut2 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (b2.slave)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (b0.slave)
  );

  // Model of the WAIT_CYCLES=2 instance
  logic [15:0] ref_mem [NW];
  logic [15:0] ref_rd;
  int          valid_q[$];

  typedef struct {
    bit          r;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
  } op_t;

  function automatic bit exp_err(bit r, bit w, logic [15:0] a);
`ifdef MEM_ERR_EN
    return (r && w) || (int'(a) >= NW);
`else
    return 1'b0;
`endif
  endfunction

  task automatic ref_apply(input op_t op);
    int i;
    i = int'(op.a) % NW;
    if (exp_err(op.r, op.w, op.a)) return;
    if (op.w) begin
      ref_mem[i] = op.d;
      valid_q.push_back(i);
    end else begin
      ref_rd = ref_mem[i];
    end
  endtask

  // Drives one request into the WAIT_CYCLES=2 instance and reports what it saw.
  task automatic issue2(input op_t op, output int lat, output logic [15:0] rd,
                        output logic er, output logic bsy);
    @(posedge clk); #1;
    b2.MemR = op.r; b2.MemW = op.w; b2.Addr = op.a; b2.WriteData = op.d;
    @(posedge clk); #1;
    b2.MemR = 1'b0; b2.MemW = 1'b0;
    bsy = b2.Busy;
    lat = 0;
    while (b2.Done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (b2.Done !== 1'b1) lat = -1;
    rd = b2.ReadData;
    er = b2.Err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ref_rd = 16'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({b2.Ready, b2.Busy, b2.Done, b2.Err, b2.ReadData} !== {4'b1000, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_idle_w2 cyc %0d: got rdy/bsy/done/err=%b%b%b%b rd=%h want 1000 rd=0000",
                 k, b2.Ready, b2.Busy, b2.Done, b2.Err, b2.ReadData);
      end
      n_tests++;
      if ({b0.Ready, b0.Busy, b0.Done, b0.Err, b0.ReadData} !== {4'b1000, 16'h0}) begin
        n_fail++;
        $display("FAIL reset_idle_w0 cyc %0d: got rdy/bsy/done/err=%b%b%b%b rd=%h want 1000 rd=0000",
                 k, b0.Ready, b0.Busy, b0.Done, b0.Err, b0.ReadData);
      end
    end
  endtask

  task automatic run_ops(input string name, input op_t ops[$]);
    int lat; logic [15:0] rd; logic er; logic bsy; bit xe;
    foreach (ops[k]) begin
      xe = exp_err(ops[k].r, ops[k].w, ops[k].a);
      issue2(ops[k], lat, rd, er, bsy);
      ref_apply(ops[k]);
      n_tests++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d want 2", name, k, lat);
      end
      n_tests++;
      if (bsy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s[%0d] busy_in_wait: got %b want 1", name, k, bsy);
      end
      n_tests++;
      if (er !== xe) begin
        n_fail++;
        $display("FAIL %s[%0d] err: got %b want %b", name, k, er, xe);
      end
      n_tests++;
      if (rd !== ref_rd) begin
        n_fail++;
        $display("FAIL %s[%0d] readdata: got %h want %h", name, k, rd, ref_rd);
      end
    end
  endtask

  task automatic test_write_read();
    op_t ops[$];
    ops.push_back('{1'b0, 1'b1, 16'h0004, 16'hBEEF});
    ops.push_back('{1'b1, 1'b0, 16'h0004, 16'h0000});
    run_ops("write_read", ops);
    @(posedge clk); #1;
    n_tests++;
    if (b2.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got Done=%b want 0", b2.Done);
    end
  endtask

  task automatic test_wait_ignore_and_reset();
    int   dones;
    int   lat; logic [15:0] rd; logic er; logic bsy;
    op_t  op;
    op = '{1'b0, 1'b1, 16'h0010, 16'h5555};
    issue2(op, lat, rd, er, bsy);
    ref_apply(op);
    // Read 0x10 while pulsing a second read during WAIT
    @(posedge clk); #1;
    b2.MemR = 1'b1; b2.Addr = 16'h0010;
    @(posedge clk); #1;
    b2.MemR = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin b2.MemR = 1'b1; b2.Addr = 16'h0004; end
      else b2.MemR = 1'b0;
      @(posedge clk); #1;
      if (b2.Done === 1'b1) dones++;
    end
    ref_rd = ref_mem[16];
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL wait_ignore dones: got %0d want 1", dones);
    end
    n_tests++;
    if (b2.ReadData !== ref_rd) begin
      n_fail++;
      $display("FAIL wait_ignore readdata: got %h want %h", b2.ReadData, ref_rd);
    end
    // Write 0xAAAA to 0x10, then reset while it sits in WAIT
    @(posedge clk); #1;
    b2.MemW = 1'b1; b2.Addr = 16'h0010; b2.WriteData = 16'hAAAA;
    @(posedge clk); #1;
    b2.MemW = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_rd = 16'h0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (b2.Done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_in_wait dones: got %0d want 0", dones);
    end
    op = '{1'b1, 1'b0, 16'h0010, 16'h0000};
    issue2(op, lat, rd, er, bsy);
    ref_apply(op);
    n_tests++;
    if (rd !== 16'h5555 || lat !== 2) begin
      n_fail++;
      $display("FAIL reset_in_wait ram: got %h lat %0d want 5555 lat 2", rd, lat);
    end
  endtask

  task automatic test_wrap_and_both();
    op_t ops[$];
    ops.push_back('{1'b0, 1'b1, 16'h0005, 16'h0BAD});
    ops.push_back('{1'b0, 1'b1, 16'h0405, 16'h1234});
    ops.push_back('{1'b1, 1'b0, 16'h0005, 16'h0000});
    ops.push_back('{1'b0, 1'b1, 16'h0002, 16'h1111});
    ops.push_back('{1'b1, 1'b1, 16'h0002, 16'h00AA});
    ops.push_back('{1'b1, 1'b0, 16'h0002, 16'h0000});
    run_ops("wrap_both", ops);
  endtask

  task automatic test_random();
    op_t ops[$];
    op_t op;
    int  kind;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      op.d = 16'($urandom);
      if (kind >= 5 && kind <= 8 && valid_q.size() > 0) begin
        op.r = 1'b1; op.w = 1'b0;
        op.a = 16'(valid_q[$urandom_range(0, valid_q.size() - 1)]);
      end else begin
        op.r = (kind == 9); op.w = 1'b1;
        op.a = 16'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 4) == 0) op.a = op.a | 16'($urandom_range(1, 63) << 10);
      ops.delete();
      ops.push_back(op);
      run_ops("random", ops);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [3];
    logic [8:0]  seen;
    // WAIT_CYCLES=0: requests held every cycle complete every cycle
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) d[k] = 16'($urandom);
    for (int k = 0; k < 6; k++) begin
      b0.MemW = (k < 3); b0.MemR = (k >= 3);
      b0.Addr = 16'((k % 3) + 1); b0.WriteData = d[k % 3];
      @(posedge clk); #1;
      n_tests++;
      if (b0.Done !== 1'b1 || b0.ReadData !== ((k < 3) ? 16'h0 : d[k - 3])) begin
        n_fail++;
        $display("FAIL b2b_w0[%0d]: got done=%b rd=%h want done=1 rd=%h", k, b0.Done,
                 b0.ReadData, (k < 3) ? 16'h0 : d[k - 3]);
      end
    end
    b0.MemR = 1'b0; b0.MemW = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (b0.Done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_w0_idle: got done=%b want 0", b0.Done);
    end
    // WAIT_CYCLES=2: a read held high completes once every three cycles
    @(posedge clk); #1;
    b2.MemR = 1'b1; b2.Addr = 16'h0004;
    seen = '0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      seen[k] = b2.Done;
    end
    b2.MemR = 1'b0;
    ref_rd = ref_mem[4];
    n_tests++;
    if (seen !== 9'b100100100) begin
      n_fail++;
      $display("FAIL b2b_w2 done pattern: got %b want 100100100", seen);
    end
    n_tests++;
    if (b2.ReadData !== ref_rd) begin
      n_fail++;
      $display("FAIL b2b_w2 readdata: got %h want %h", b2.ReadData, ref_rd);
    end
  endtask

  initial begin
    b2.MemR = 1'b0; b2.MemW = 1'b0; b2.Addr = '0; b2.WriteData = '0;
    b0.MemR = 1'b0; b0.MemW = 1'b0; b0.Addr = '0; b0.WriteData = '0;
    test_reset();
    test_write_read();
    test_wait_ignore_and_reset();
    test_wrap_and_both();
    test_random();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
